r2_compute_with_pbc: RTL and testbench

//  Pipelined squared-distance unit for the range-limited MD force pipeline.

---
 rtl/r2_compute_with_pbc_pkg.sv | 101 ++++++++++
 rtl/r2_pbc_axis.sv | 46 ++++
 rtl/r2_compute_with_pbc.sv | 90 +++++++++
 tb/tb_r2_compute_with_pbc.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/r2_compute_with_pbc_pkg.sv
// Shared types, latency constants and IEEE-754 single-precision helpers for the
// r2/PBC pipeline (round-to-nearest-even, denormals flushed to zero).
package r2_compute_with_pbc_pkg;
  localparam int DATA_WIDTH    = 32;
  localparam int SUB_LAT       = 3;
  localparam int MUL_LAT       = 4;
  localparam int MUL_ADD_LAT   = 5;
  localparam int PBC_LAT       = 2 * SUB_LAT;
  localparam int TOTAL_LATENCY = PBC_LAT + MUL_LAT + 2 * MUL_ADD_LAT;
  localparam int DY_DELAY      = MUL_LAT;
  localparam int DZ_DELAY      = MUL_LAT + MUL_ADD_LAT;
  localparam int OUT_DELAY     = TOTAL_LATENCY - PBC_LAT;

  typedef logic [DATA_WIDTH-1:0] fp32_t;

  localparam fp32_t NEG_ZERO = 32'h8000_0000;

  // Sign-magnitude ordering; +0 and -0 compare equal.
  function automatic logic fp_gt(input fp32_t a, input fp32_t b);
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
    else if (a[31] != b[31]) return ~a[31];
    else if (!a[31]) return a[30:0] > b[30:0];
    else return a[30:0] < b[30:0];
  endfunction

  // man holds 1.xxx at bit 26 followed by guard, round and sticky bits.
  function automatic fp32_t fp_pack(input logic sgn, input logic signed [9:0] exp_i,
                                    input logic [26:0] man);
    logic [24:0] rnd;
    logic signed [9:0] e;
    logic up;
    up  = man[2] & (man[1] | man[0] | man[3]);
    rnd = {1'b0, man[26:3]} + {24'd0, up};
    e   = exp_i;
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e   = e + 10'sd1;
    end else begin
      e   = exp_i;
    end
    if (e <= 10'sd0 || !rnd[23]) return {sgn, 31'd0};
    else if (e >= 10'sd255) return {sgn, 8'hFF, 23'd0};
    else return {sgn, e[7:0], rnd[22:0]};
  endfunction

  function automatic fp32_t fp_add(input fp32_t a, input fp32_t b);
    fp32_t big, sml;
    logic [23:0] mb, ms;
    logic [7:0] diff;
    logic [4:0] sh, lz;
    logic [49:0] wide;
    logic [26:0] xs, n;
    logic [27:0] sum;
    logic signed [9:0] e;
    if (a[30:0] >= b[30:0]) begin
      big = a; sml = b;
    end else begin
      big = b; sml = a;
    end
    if (big[30:23] == 8'hFF) return big;
    mb   = (big[30:23] == 8'd0) ? 24'd0 : {1'b1, big[22:0]};
    ms   = (sml[30:23] == 8'd0) ? 24'd0 : {1'b1, sml[22:0]};
    diff = big[30:23] - sml[30:23];
    sh   = (diff > 8'd31) ? 5'd31 : diff[4:0];
    wide = {ms, 26'd0} >> sh;
    xs   = {wide[49:24], wide[23] | (|wide[22:0])};
    if (big[31] == sml[31]) sum = {1'b0, mb, 3'd0} + {1'b0, xs};
    else sum = {1'b0, mb, 3'd0} - {1'b0, xs};
    if (sum == 28'd0) return 32'd0;
    e = {2'b00, big[30:23]};
    if (sum[27]) begin
      n = {sum[27:2], sum[1] | sum[0]};
      e = e + 10'sd1;
    end else begin
      lz = 5'd0;
      for (int i = 0; i < 27; i++) lz = sum[i] ? 5'(26 - i) : lz;
      n = sum[26:0] << lz;
      e = e - $signed({5'd0, lz});
    end
    return fp_pack(big[31], e, n);
  endfunction

  function automatic fp32_t fp_mul(input fp32_t a, input fp32_t b);
    logic sgn;
    logic [47:0] p;
    logic [26:0] n;
    logic signed [9:0] e;
    sgn = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {sgn, 31'd0};
    else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {sgn, 8'hFF, 23'd0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) begin
      n = {p[47:22], |p[21:0]};
      e = e + 10'sd1;
    end else begin
      n = {p[46:21], |p[20:0]};
    end
    return fp_pack(sgn, e, n);
  endfunction
endpackage

// File: rtl/r2_pbc_axis.sv
// One axis of the displacement front end: d = ref - nbr, then minimum-image
// wrap against the box half-lengths. d_pbc leaves 6 cycles after the inputs.
module r2_pbc_axis
  import r2_compute_with_pbc_pkg::*;
#(
  parameter fp32_t BOX      = 32'h426E0000,
  parameter fp32_t HALF_POS = 32'h41EE0000,
  parameter fp32_t HALF_NEG = 32'hC1EE0000
) (
  input  logic  clk,
  input  logic  rst,
  input  fp32_t ref_v,
  input  fp32_t nbr_v,
  output fp32_t d_pbc
);
  fp32_t d_r   [SUB_LAT];
  fp32_t pbc_r [SUB_LAT];
  fp32_t corr_s;

  // Strict compares: a displacement of exactly +/- half a box stays unwrapped.
  always_comb begin
    corr_s = NEG_ZERO;
    if (fp_gt(d_r[SUB_LAT-1], HALF_POS)) corr_s = {1'b1, BOX[30:0]};
    else if (fp_gt(HALF_NEG, d_r[SUB_LAT-1])) corr_s = BOX;
    else corr_s = NEG_ZERO;
  end

  // Subtract stage followed by the correction-add stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SUB_LAT; i++) begin
        d_r[i]   <= 32'd0;
        pbc_r[i] <= 32'd0;
      end
    end else begin
      d_r[0]   <= fp_add(ref_v, {~nbr_v[31], nbr_v[30:0]});
      pbc_r[0] <= fp_add(d_r[SUB_LAT-1], corr_s);
      for (int i = 1; i < SUB_LAT; i++) begin
        d_r[i]   <= d_r[i-1];
        pbc_r[i] <= pbc_r[i-1];
      end
    end
  end

  assign d_pbc = pbc_r[SUB_LAT-1];
endmodule

// File: rtl/r2_compute_with_pbc.sv
// Pipelined minimum-image displacement and squared distance, one pair per
// cycle, fixed 20-cycle latency from input sampling to r2_valid.
module r2_compute_with_pbc
  import r2_compute_with_pbc_pkg::*;
#(
  parameter fp32_t BOUNDING_BOX_X          = 32'h426E0000,
  parameter fp32_t BOUNDING_BOX_Y          = 32'h424C0000,
  parameter fp32_t BOUNDING_BOX_Z          = 32'h424C0000,
  parameter fp32_t HALF_BOUNDING_BOX_X_POS = 32'h41EE0000,
  parameter fp32_t HALF_BOUNDING_BOX_Y_POS = 32'h41CC0000,
  parameter fp32_t HALF_BOUNDING_BOX_Z_POS = 32'h41CC0000,
  parameter fp32_t HALF_BOUNDING_BOX_X_NEG = 32'hC1EE0000,
  parameter fp32_t HALF_BOUNDING_BOX_Y_NEG = 32'hC1CC0000,
  parameter fp32_t HALF_BOUNDING_BOX_Z_NEG = 32'hC1CC0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] refx,
  input  logic [DATA_WIDTH-1:0] refy,
  input  logic [DATA_WIDTH-1:0] refz,
  input  logic [DATA_WIDTH-1:0] neighborx,
  input  logic [DATA_WIDTH-1:0] neighbory,
  input  logic [DATA_WIDTH-1:0] neighborz,
  output logic [DATA_WIDTH-1:0] r2,
  output logic [DATA_WIDTH-1:0] dx_out,
  output logic [DATA_WIDTH-1:0] dy_out,
  output logic [DATA_WIDTH-1:0] dz_out,
  output logic                  r2_valid
);
  fp32_t dx_s, dy_s, dz_s;
  fp32_t x2_r   [MUL_LAT];
  fp32_t s_r    [MUL_ADD_LAT];
  fp32_t r2_r   [MUL_ADD_LAT];
  fp32_t dx_d_r [OUT_DELAY];
  fp32_t dy_d_r [OUT_DELAY];
  fp32_t dz_d_r [OUT_DELAY];
  logic [TOTAL_LATENCY-1:0] valid_r;

  r2_pbc_axis #(.BOX(BOUNDING_BOX_X), .HALF_POS(HALF_BOUNDING_BOX_X_POS),
                .HALF_NEG(HALF_BOUNDING_BOX_X_NEG))
    u_axis_x (.clk(clk), .rst(rst), .ref_v(refx), .nbr_v(neighborx), .d_pbc(dx_s));
  r2_pbc_axis #(.BOX(BOUNDING_BOX_Y), .HALF_POS(HALF_BOUNDING_BOX_Y_POS),
                .HALF_NEG(HALF_BOUNDING_BOX_Y_NEG))
    u_axis_y (.clk(clk), .rst(rst), .ref_v(refy), .nbr_v(neighbory), .d_pbc(dy_s));
  r2_pbc_axis #(.BOX(BOUNDING_BOX_Z), .HALF_POS(HALF_BOUNDING_BOX_Z_POS),
                .HALF_NEG(HALF_BOUNDING_BOX_Z_NEG))
    u_axis_z (.clk(clk), .rst(rst), .ref_v(refz), .nbr_v(neighborz), .d_pbc(dz_s));

  // Square/accumulate stages; dy and dz taps sit where their partner sum arrives
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MUL_LAT; i++) x2_r[i] <= 32'd0;
      for (int i = 0; i < MUL_ADD_LAT; i++) begin
        s_r[i]  <= 32'd0;
        r2_r[i] <= 32'd0;
      end
      for (int i = 0; i < OUT_DELAY; i++) begin
        dx_d_r[i] <= 32'd0;
        dy_d_r[i] <= 32'd0;
        dz_d_r[i] <= 32'd0;
      end
      valid_r <= {TOTAL_LATENCY{1'b0}};
    end else begin
      x2_r[0]   <= fp_mul(dx_s, dx_s);
      s_r[0]    <= fp_add(fp_mul(dy_d_r[DY_DELAY-1], dy_d_r[DY_DELAY-1]), x2_r[MUL_LAT-1]);
      r2_r[0]   <= fp_add(fp_mul(dz_d_r[DZ_DELAY-1], dz_d_r[DZ_DELAY-1]), s_r[MUL_ADD_LAT-1]);
      dx_d_r[0] <= dx_s;
      dy_d_r[0] <= dy_s;
      dz_d_r[0] <= dz_s;
      for (int i = 1; i < MUL_LAT; i++) x2_r[i] <= x2_r[i-1];
      for (int i = 1; i < MUL_ADD_LAT; i++) begin
        s_r[i]  <= s_r[i-1];
        r2_r[i] <= r2_r[i-1];
      end
      for (int i = 1; i < OUT_DELAY; i++) begin
        dx_d_r[i] <= dx_d_r[i-1];
        dy_d_r[i] <= dy_d_r[i-1];
        dz_d_r[i] <= dz_d_r[i-1];
      end
      valid_r <= {valid_r[TOTAL_LATENCY-2:0], enable};
    end
  end

  assign r2       = r2_r[MUL_ADD_LAT-1];
  assign dx_out   = dx_d_r[OUT_DELAY-1];
  assign dy_out   = dy_d_r[OUT_DELAY-1];
  assign dz_out   = dz_d_r[OUT_DELAY-1];
  assign r2_valid = valid_r[TOTAL_LATENCY-1];
endmodule

// File: tb/tb_r2_compute_with_pbc.sv
// Scoreboard bench: stimulus pushes expected results computed with real
// arithmetic on quarter-grid coordinates; a monitor pops on every r2_valid.
module tb_r2_compute_with_pbc;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] refx, refy, refz, neighborx, neighbory, neighborz;
  logic [31:0] r2, dx_out, dy_out, dz_out;
  logic        r2_valid;

  typedef struct {
    logic [31:0] r2;
    logic [31:0] dx;
    logic [31:0] dy;
    logic [31:0] dz;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  r2_compute_with_pbc dut (
    .clk(clk), .rst(rst), .enable(enable),
    .refx(refx), .refy(refy), .refz(refz),
    .neighborx(neighborx), .neighbory(neighbory), .neighborz(neighborz),
    .r2(r2), .dx_out(dx_out), .dy_out(dy_out), .dz_out(dz_out), .r2_valid(r2_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Exact for the quarter-grid values used here, so no rounding is needed.
  function automatic logic [31:0] to_f32(input real v);
    logic [63:0] b;
    logic [10:0] e64;
    if (v == 0.0) return 32'd0;
    b   = $realtobits(v);
    e64 = b[62:52];
    return {b[63], 8'(e64 - 11'd896), b[51:29]};
  endfunction

  function automatic real wrap(input real d, input real box);
    if (d > box / 2.0) return d - box;
    else if (d < -box / 2.0) return d + box;
    else return d;
  endfunction

  function automatic real rq();
    return real'($urandom_range(0, 255)) / 4.0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && r2_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_valid: got r2_valid=1 expected 0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("latency", 32'(cyc), 32'(e.due));
        check("r2", r2, e.r2);
        check("dx", dx_out, e.dx);
        check("dy", dy_out, e.dy);
        check("dz", dz_out, e.dz);
      end
    end
  end

  task automatic drive(input real rx, ry, rz, nx, ny, nz);
    exp_t e;
    real  dx, dy, dz;
    @(posedge clk); #1;
    enable    = 1'b1;
    refx      = to_f32(rx);
    refy      = to_f32(ry);
    refz      = to_f32(rz);
    neighborx = to_f32(nx);
    neighbory = to_f32(ny);
    neighborz = to_f32(nz);
    dx    = wrap(rx - nx, 59.5);
    dy    = wrap(ry - ny, 51.0);
    dz    = wrap(rz - nz, 51.0);
    e.dx  = to_f32(dx);
    e.dy  = to_f32(dy);
    e.dz  = to_f32(dz);
    e.r2  = to_f32(dx * dx + dy * dy + dz * dz);
    e.due = cyc + 20;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      enable    = 1'b0;
      refx      = $urandom();
      refy      = $urandom();
      refz      = $urandom();
      neighborx = $urandom();
      neighbory = $urandom();
      neighborz = $urandom();
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0;
    refx = 32'd0; refy = 32'd0; refz = 32'd0;
    neighborx = 32'd0; neighbory = 32'd0; neighborz = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_valid", 32'(r2_valid), 32'd0);
    check("reset_r2", r2, 32'd0);
    check("reset_dx", dx_out, 32'd0);
    check("reset_dy", dy_out, 32'd0);
    check("reset_dz", dz_out, 32'd0);
    rst = 1'b1;

    drive(2.0, 4.0, 8.0, 1.0, 1.0, 1.0);
    idle(25);
    drive(2.0, 4.0, 8.0, 1.0, 1.0, 1.0);
    drive(2.0, 2.0, 2.0, 1.0, 1.0, 1.0);
    drive(1.0, 1.0, 1.0, 2.0, 4.0, 8.0);
    idle(25);
    drive(59.0, 50.5, 50.5, 0.0, 0.0, 0.0);
    drive(0.0, 0.0, 0.0, 59.0, 50.5, 50.5);
    drive(29.75, 25.5, 25.5, 0.0, 0.0, 0.0);
    drive(0.0, 0.0, 0.0, 29.75, 25.5, 25.5);
    drive(29.75, 25.5, 25.5, 29.75, 25.5, 25.5);
    idle(25);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) drive(rq(), rq(), rq(), rq(), rq(), rq());
      else idle(1);
    end
    idle(25);

    for (int i = 0; i < 6; i++) drive(rq(), rq(), rq(), rq(), rq(), rq());
    idle(5);
    #2;
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(r2_valid), 32'd0);
    check("rst_r2", r2, 32'd0);
    check("rst_dx", dx_out, 32'd0);
    check("rst_dy", dy_out, 32'd0);
    check("rst_dz", dz_out, 32'd0);
    sbq.delete();
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_valid", 32'(r2_valid), 32'd0);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    idle(30);
    drive(2.0, 4.0, 8.0, 1.0, 1.0, 1.0);
    idle(25);

    check("drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
